// File: rtl/pe_dot_acc.sv
// pe_dot_acc: multi-lane dot-product processing element with frame accumulation.
//
// Each valid beat carries LANES signed activation/weight pairs. Stage 1 registers
// the per-lane products together with the seed partial sum and beat framing.
// Stage 2 sums the products and either starts a new frame from the seed partial
// sum or adds to the running accumulator. One result is emitted per frame, either
// saturated (SAT=1) or wrapped (SAT=0) on overflow.
//
// Parameters:
//   XW, WW  - signed activation / weight widths
//   LANES   - products per beat
//   ACCW    - accumulator width; must be >= XW+WW+clog2(LANES)
//   SAT     - 1: clamp on overflow, 0: wrap modulo 2^ACCW
//
// Ports:
//   iCLK    - clock, all state on the rising edge
//   iRSTn   - asynchronous active-low reset
//   iClr    - synchronous clear/abort, overrides every other input
//   iValid  - input beat valid
//   iLast   - last beat of the frame (qualified by iValid)
//   iX      - activations, lane k at [k*XW +: XW]
//   iW      - weights, lane k at [k*WW +: WW]
//   iPsum   - seed partial sum, used only on a frame's first beat
//   oValid  - one-cycle pulse when oPsum carries a new frame result
//   oPsum   - frame result, held until the next result
//   oSat    - overflow seen in the reported frame, held with oPsum
//   oBusy   - a frame is open in stage 2

module pe_dot_acc #(
    parameter int unsigned XW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned ACCW  = 24,
    parameter bit          SAT   = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRSTn,
    input  logic                  iClr,
    input  logic                  iValid,
    input  logic                  iLast,
    input  logic [LANES*XW-1:0]   iX,
    input  logic [LANES*WW-1:0]   iW,
    input  logic [ACCW-1:0]       iPsum,
    output logic                  oValid,
    output logic [ACCW-1:0]       oPsum,
    output logic                  oSat,
    output logic                  oBusy
);

    localparam int unsigned PW = XW + WW;

    localparam logic [ACCW-1:0] AccMax = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] AccMin = {1'b1, {(ACCW-1){1'b0}}};

    typedef enum logic {
        StIdle,
        StAcc
    } state_e;

    // ------------------------------------------------------------------------
    // Stage 1: per-lane signed products
    // ------------------------------------------------------------------------
    logic signed [PW-1:0] x_ext  [LANES];
    logic signed [PW-1:0] w_ext  [LANES];
    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic [ACCW-1:0]      psum_q;
    logic                 beat_valid_q;
    logic                 beat_last_q;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            // Sign-extend both operands to the full product width so the
            // multiply is exact and width-matched.
            x_ext[k]  = {{WW{iX[k*XW+XW-1]}}, iX[k*XW +: XW]};
            w_ext[k]  = {{XW{iW[k*WW+WW-1]}}, iW[k*WW +: WW]};
            prod_d[k] = x_ext[k] * w_ext[k];
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
            end
            psum_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
        end else if (iClr) begin
            // Drops both the beat already in stage 1 and the one on the inputs.
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
            end
            psum_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
        end else begin
            beat_valid_q <= iValid;
            beat_last_q  <= iValid & iLast;
            if (iValid) begin
                for (int k = 0; k < LANES; k++) begin
                    prod_q[k] <= prod_d[k];
                end
                psum_q <= iPsum;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: lane reduction and accumulator update
    // ------------------------------------------------------------------------
    state_e            state_q;
    logic [ACCW-1:0]   acc_q;
    logic              ovf_flag_q;
    logic              out_valid_q;
    logic [ACCW-1:0]   out_psum_q;
    logic              out_sat_q;

    logic signed [ACCW-1:0] dot;
    logic [ACCW-1:0]        acc_base;
    logic [ACCW:0]          sum_wide;
    logic                   sum_ovf;
    logic [ACCW-1:0]        acc_d;
    logic                   ovf_flag_d;

    always_comb begin
        dot = '0;
        for (int k = 0; k < LANES; k++) begin
            // ACCW is wide enough that the lane sum itself cannot overflow.
            dot = dot + ACCW'(prod_q[k]);
        end
    end

    always_comb begin
        // A frame's first beat starts from the seed captured with it.
        acc_base = (state_q == StIdle) ? psum_q : acc_q;
        sum_wide = {acc_base[ACCW-1], acc_base} + {dot[ACCW-1], dot};
        sum_ovf  = sum_wide[ACCW] ^ sum_wide[ACCW-1];

        acc_d = sum_wide[ACCW-1:0];
        if (SAT && sum_ovf) begin
            // The extra top bit holds the true sign of the sum.
            acc_d = sum_wide[ACCW] ? AccMin : AccMax;
        end

        ovf_flag_d = sum_ovf | ((state_q == StAcc) & ovf_flag_q);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (iClr) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (beat_valid_q) begin
                acc_q      <= acc_d;
                ovf_flag_q <= ovf_flag_d;
                unique case (state_q)
                    StIdle, StAcc: begin
                        if (beat_last_q) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b1;
                            out_psum_q  <= acc_d;
                            out_sat_q   <= ovf_flag_d;
                        end else begin
                            state_q <= StAcc;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign oValid = out_valid_q;
    assign oPsum  = out_psum_q;
    assign oSat   = out_sat_q;
    assign oBusy  = (state_q == StAcc);

endmodule

// File: tb/tb_pe_dot_acc.sv
// tb_pe_dot_acc: directed bench for pe_dot_acc. Two instances share all inputs:
// one saturating (SAT=1), one wrapping (SAT=0). Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point.

module tb_pe_dot_acc;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        valid;
    logic        last;
    logic [31:0] x;
    logic [31:0] w;
    logic [23:0] psum;

    logic        ov_s, sat_s, busy_s;
    logic [23:0] ps_s;
    logic        ov_w, sat_w, busy_w;
    logic [23:0] ps_w;

    int tests_run;
    int tests_failed;

    pe_dot_acc #(.XW(8), .WW(8), .LANES(4), .ACCW(24), .SAT(1'b1)) dut_s (
        .iCLK   (clk),
        .iRSTn  (rst_n),
        .iClr   (clr),
        .iValid (valid),
        .iLast  (last),
        .iX     (x),
        .iW     (w),
        .iPsum  (psum),
        .oValid (ov_s),
        .oPsum  (ps_s),
        .oSat   (sat_s),
        .oBusy  (busy_s)
    );

    pe_dot_acc #(.XW(8), .WW(8), .LANES(4), .ACCW(24), .SAT(1'b0)) dut_w (
        .iCLK   (clk),
        .iRSTn  (rst_n),
        .iClr   (clr),
        .iValid (valid),
        .iLast  (last),
        .iX     (x),
        .iW     (w),
        .iPsum  (psum),
        .oValid (ov_w),
        .oPsum  (ps_w),
        .oSat   (sat_w),
        .oBusy  (busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] xv, input logic [31:0] wv,
                         input logic [23:0] pv, input logic v, input logic l);
        x     = xv;
        w     = wv;
        psum  = pv;
        valid = v;
        last  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom(), $urandom(), 24'($urandom()), 1'b1, 1'($urandom()));
            tick();
        end
        tests_run++;
        if ({ov_s, ps_s, sat_s, busy_s} !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: got v=%b p=%0d s=%b b=%b want all 0",
                     ov_s, ps_s, sat_s, busy_s);
        end
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if ({ov_s, ps_s, sat_s, busy_s, ov_w, ps_w, sat_w, busy_w} !== 54'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got v=%b p=%0d s=%b b=%b want all 0",
                     ov_s, ps_s, sat_s, busy_s);
        end
    endtask

    task automatic test_single_beat();
        // dot = 1*5 + 2*6 + 3*7 + 4*8 = 70, plus seed 10
        drive(32'h04030201, 32'h08070605, 24'd10, 1'b1, 1'b1);
        tick();
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tests_run++;
        if (ov_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: oValid=%b want 0 after one edge", ov_s);
        end
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd80 || sat_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b p=%0d s=%b want v=1 p=80 s=0",
                     ov_s, ps_s, sat_s);
        end
        tests_run++;
        if (ov_w !== 1'b1 || ps_w !== 24'd80 || sat_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result_wrap: got v=%b p=%0d s=%b want v=1 p=80 s=0",
                     ov_w, ps_w, sat_w);
        end
        tick();
        tests_run++;
        if (ov_s !== 1'b0 || ps_s !== 24'd80) begin
            tests_failed++;
            $display("FAIL single_hold: got v=%b p=%0d want v=0 p=80", ov_s, ps_s);
        end
    endtask

    task automatic test_gap_frame();
        // dot = 4 * (1*2) = 8 per beat; 100 + 3*8 = 124
        drive(32'h01010101, 32'h02020202, 24'd100, 1'b1, 1'b0);
        tick();
        drive(32'h01010101, 32'h02020202, 24'd999, 1'b0, 1'b1);
        tick();
        tick();
        tests_run++;
        if (busy_s !== 1'b1 || ov_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_busy: got busy=%b v=%b want busy=1 v=0", busy_s, ov_s);
        end
        drive(32'h01010101, 32'h02020202, 24'd999, 1'b1, 1'b0);
        tick();
        drive(32'h01010101, 32'h02020202, 24'd999, 1'b1, 1'b1);
        tick();
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tests_run++;
        if (busy_s !== 1'b1 || ov_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_mid: got busy=%b v=%b want busy=1 v=0", busy_s, ov_s);
        end
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd124 || sat_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_result: got v=%b p=%0d s=%b busy=%b want v=1 p=124 s=0 busy=0",
                     ov_s, ps_s, sat_s, busy_s);
        end
        tick();
        tests_run++;
        if (ov_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_pulse: oValid=%b want 0 one cycle after result", ov_s);
        end
    endtask

    task automatic test_saturation();
        // Each beat adds 4 * 16384 = 65536; 128 beats reach exactly 2^23.
        for (int i = 0; i < 128; i++) begin
            drive(32'h80808080, 32'h80808080, 24'd0, 1'b1, (i == 127));
            tick();
        end
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'h7FFFFF || sat_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_clamp: got v=%b p=%h s=%b want v=1 p=7fffff s=1",
                     ov_s, ps_s, sat_s);
        end
        tests_run++;
        if (ov_w !== 1'b1 || ps_w !== 24'h800000 || sat_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_wrap: got v=%b p=%h s=%b want v=1 p=800000 s=1",
                     ov_w, ps_w, sat_w);
        end
        tick();
    endtask

    task automatic test_abort();
        drive(32'h01010101, 32'h01010101, 24'd0, 1'b1, 1'b0);
        tick();
        tick();
        drive(32'h01010101, 32'h01010101, 24'd0, 1'b1, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tests_run++;
        if (ov_s !== 1'b0 || ps_s !== 24'd0 || busy_s !== 1'b0 || sat_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_clear: got v=%b p=%0d busy=%b s=%b want all 0",
                     ov_s, ps_s, busy_s, sat_s);
        end
        tick();
        tick();
        tests_run++;
        if (ov_s !== 1'b0 || ov_w !== 1'b0 || ps_s !== 24'd0) begin
            tests_failed++;
            $display("FAIL abort_noresult: got v=%b p=%0d want v=0 p=0", ov_s, ps_s);
        end
        drive(32'h01010101, 32'h01010101, 24'd0, 1'b1, 1'b1);
        tick();
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd4) begin
            tests_failed++;
            $display("FAIL abort_next: got v=%b p=%0d want v=1 p=4", ov_s, ps_s);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(32'h01010101, 32'h01010101, 24'd0, 1'b1, 1'b1);
        tick();
        drive(32'h01010101, 32'h01010101, 24'd1, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd4) begin
            tests_failed++;
            $display("FAIL b2b_0: got v=%b p=%0d want v=1 p=4", ov_s, ps_s);
        end
        drive(32'h01010101, 32'h01010101, 24'd2, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd5) begin
            tests_failed++;
            $display("FAIL b2b_1: got v=%b p=%0d want v=1 p=5", ov_s, ps_s);
        end
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd6) begin
            tests_failed++;
            $display("FAIL b2b_2: got v=%b p=%0d want v=1 p=6", ov_s, ps_s);
        end
        tick();
        tests_run++;
        if (ov_s !== 1'b0 || ps_s !== 24'd6) begin
            tests_failed++;
            $display("FAIL b2b_end: got v=%b p=%0d want v=0 p=6", ov_s, ps_s);
        end
    endtask

    task automatic test_reset_midframe();
        drive(32'h01010101, 32'h01010101, 24'd50, 1'b1, 1'b0);
        tick();
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (busy_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy: got busy=%b want 1", busy_s);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy_s !== 1'b0 || ps_s !== 24'd0 || ov_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: got busy=%b p=%0d v=%b want all 0",
                     busy_s, ps_s, ov_s);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ov_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_lost: got v=%b busy=%b want 0 0", ov_s, busy_s);
        end
        drive(32'h01010101, 32'h01010101, 24'd0, 1'b1, 1'b1);
        tick();
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (ov_s !== 1'b1 || ps_s !== 24'd4) begin
            tests_failed++;
            $display("FAIL midrst_new: got v=%b p=%0d want v=1 p=4", ov_s, ps_s);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        drive(32'd0, 32'd0, 24'd0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_single_beat();
        test_gap_frame();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
